// File: rtl/est_output_mxv_pkg.sv
// Shared fixed-point types and helpers for the estimate-output datapath.
package est_output_mxv_pkg;

   localparam int FXP_N    = 16;
   localparam int FXP_FRAC = 8;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MAC  = 1'b1
   } mxv_state_e;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) res = res + 1;
      return res;
   endfunction

   // Index widths never collapse to zero bits, even for a single row/pair.
   function automatic int clog2_min1(input int value);
      return (value > 1) ? clog2(value) : 1;
   endfunction

endpackage

// File: rtl/fxp_mul.sv
// Signed fixed-point multiplier: full 2N-bit product plus an N-bit truncated view.
module fxp_mul #(
   parameter int N    = 16,
   parameter int FRAC = 8
) (
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] y_full,
   output logic [N-1:0]   y_trunc
);

   logic [2*N-1:0] a_ext;
   logic [2*N-1:0] b_ext;

   // Sign-extended operands make the modulo-2^2N product the exact signed product.
   assign a_ext   = {{N{a[N-1]}}, a};
   assign b_ext   = {{N{b[N-1]}}, b};
   assign y_full  = a_ext * b_ext;
   assign y_trunc = y_full[FRAC +: N];

endmodule

// File: rtl/fxp_round_sat.sv
// Wide accumulator to N-bit fixed-point conversion: optional round-half-up,
// arithmetic shift by FRAC, then saturate or wrap.
module fxp_round_sat #(
   parameter int IW    = 33,
   parameter int N     = 16,
   parameter int FRAC  = 8,
   parameter int ROUND = 0,
   parameter int SAT   = 0
) (
   input  logic [IW-1:0] din,
   output logic [N-1:0]  dout
);

   localparam logic [IW-1:0] RND  = (ROUND != 0 && FRAC > 0) ?
                                    (IW'(1) << ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
   localparam logic [IW-1:0] MAXV = {{(IW-N+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic [IW-1:0] MINV = ~MAXV;

   logic [IW-1:0] v;
   logic [IW-1:0] r;
   logic          over;
   logic          under;

   assign v     = din + RND;
   assign r     = $signed(v) >>> FRAC;
   assign over  = $signed(r) > $signed(MAXV);
   assign under = $signed(r) < $signed(MINV);

   always_comb begin
      dout = r[N-1:0];
      if (SAT != 0) begin
         if (over)       dout = MAXV[N-1:0];
         else if (under) dout = MINV[N-1:0];
      end
   end

endmodule

// File: rtl/est_output_mxv.sv
// Serial z = H*x for the estimate-output stage: two products per cycle, one row
// result rounded/saturated and written to Z on the last pair of each row.
//
// state   | meaning
// ST_IDLE | waiting for start; operands captured on acceptance
// ST_MAC  | one column pair per cycle, row result written on the last pair
module est_output_mxv
   import est_output_mxv_pkg::*;
#(
   parameter int N     = FXP_N,
   parameter int FRAC  = FXP_FRAC,
   parameter int ROWS  = 2,
   parameter int COLS  = 2,
   parameter int ROUND = 0,
   parameter int SAT   = 0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [ROWS*COLS*N-1:0]        h_flat,
   input  logic [COLS*N-1:0]             x_flat,
   output logic                          busy,
   output logic                          row_valid,
   output logic [clog2_min1(ROWS)-1:0]   row_idx,
   output logic                          done,
   output logic [ROWS*N-1:0]             Z
);

   localparam int CPR = (COLS + 1) / 2;
   localparam int RW  = clog2_min1(ROWS);
   localparam int PW  = clog2_min1(CPR);
   localparam int AW  = 2*N + clog2(COLS) + 1;

   mxv_state_e             state_q, state_d;
   logic [ROWS*COLS*N-1:0] h_q, h_d;
   logic [COLS*N-1:0]      x_q, x_d;
   logic [RW-1:0]          row_q, row_d;
   logic [RW-1:0]          row_idx_q, row_idx_d;
   logic [PW-1:0]          pair_q, pair_d;
   logic [AW-1:0]          acc_q, acc_d;
   logic [ROWS*N-1:0]      z_q, z_d;
   logic                   busy_q, busy_d;
   logic                   row_valid_q, row_valid_d;
   logic                   done_q, done_d;

   logic [N-1:0]   h0, h1, x0, x1, res;
   logic [2*N-1:0] m0, m1;
   logic [N-1:0]   mul0_trunc_unused, mul1_trunc_unused;
   logic [AW-1:0]  sum;
   logic           last_pair, last_row;

   // Odd COLS: the second slot of the final pair matches no column and stays zero.
   always_comb begin
      h0 = '0;
      h1 = '0;
      x0 = '0;
      x1 = '0;
      for (int c = 0; c < COLS; c++) begin
         if (c == 2*int'(pair_q)) begin
            x0 = x_q[c*N +: N];
            for (int r = 0; r < ROWS; r++)
               if (r == int'(row_q)) h0 = h_q[(r*COLS+c)*N +: N];
         end
         if (c == 2*int'(pair_q) + 1) begin
            x1 = x_q[c*N +: N];
            for (int r = 0; r < ROWS; r++)
               if (r == int'(row_q)) h1 = h_q[(r*COLS+c)*N +: N];
         end
      end
   end

   fxp_mul #(.N(N), .FRAC(FRAC)) u_mul0 (
      .a       (h0),
      .b       (x0),
      .y_full  (m0),
      .y_trunc (mul0_trunc_unused)
   );

   fxp_mul #(.N(N), .FRAC(FRAC)) u_mul1 (
      .a       (h1),
      .b       (x1),
      .y_full  (m1),
      .y_trunc (mul1_trunc_unused)
   );

   assign sum = ((pair_q == '0) ? '0 : acc_q)
              + {{(AW-2*N){m0[2*N-1]}}, m0}
              + {{(AW-2*N){m1[2*N-1]}}, m1};

   fxp_round_sat #(.IW(AW), .N(N), .FRAC(FRAC), .ROUND(ROUND), .SAT(SAT)) u_round_sat (
      .din  (sum),
      .dout (res)
   );

   assign last_pair = (pair_q == PW'(CPR - 1));
   assign last_row  = (row_q == RW'(ROWS - 1));

   always_comb begin
      state_d     = state_q;
      h_d         = h_q;
      x_d         = x_q;
      row_d       = row_q;
      pair_d      = pair_q;
      acc_d       = acc_q;
      z_d         = z_q;
      busy_d      = busy_q;
      row_idx_d   = row_idx_q;
      row_valid_d = 1'b0;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_MAC;
               h_d     = h_flat;
               x_d     = x_flat;
               row_d   = '0;
               pair_d  = '0;
               busy_d  = 1'b1;
            end
         end
         ST_MAC: begin
            acc_d = sum;
            if (last_pair) begin
               for (int r = 0; r < ROWS; r++)
                  if (r == int'(row_q)) z_d[r*N +: N] = res;
               row_valid_d = 1'b1;
               row_idx_d   = row_q;
               pair_d      = '0;
               if (last_row) begin
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  row_d = row_q + RW'(1);
               end
            end else begin
               pair_d = pair_q + PW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         h_q         <= '0;
         x_q         <= '0;
         row_q       <= '0;
         pair_q      <= '0;
         acc_q       <= '0;
         z_q         <= '0;
         busy_q      <= 1'b0;
         row_idx_q   <= '0;
         row_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         h_q         <= h_d;
         x_q         <= x_d;
         row_q       <= row_d;
         pair_q      <= pair_d;
         acc_q       <= acc_d;
         z_q         <= z_d;
         busy_q      <= busy_d;
         row_idx_q   <= row_idx_d;
         row_valid_q <= row_valid_d;
         done_q      <= done_d;
      end
   end

   assign busy      = busy_q;
   assign row_valid = row_valid_q;
   assign row_idx   = row_idx_q;
   assign done      = done_q;
   assign Z         = z_q;

endmodule

// File: tb/tb_est_output_mxv.sv
// Directed bench for est_output_mxv across 2x2, 3x3, saturating and 1x1 rounding configurations.
module tb_est_output_mxv;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   // A: 2x2 truncate/wrap
   logic        a_start, a_busy, a_rv, a_done;
   logic [63:0] a_h;
   logic [31:0] a_x, a_z;
   logic [0:0]  a_idx;
   // B: 3x3 truncate/wrap
   logic         b_start, b_busy, b_rv, b_done;
   logic [143:0] b_h;
   logic [47:0]  b_x, b_z;
   logic [1:0]   b_idx;
   // C: 2x2 saturating
   logic        c_start, c_busy, c_rv, c_done;
   logic [63:0] c_h;
   logic [31:0] c_x, c_z;
   logic [0:0]  c_idx;
   // D/E: 1x1 truncate / round-half-up
   logic        d_start, d_busy, d_rv, d_done;
   logic [15:0] d_h, d_x, d_z;
   logic [0:0]  d_idx;
   logic        e_start, e_busy, e_rv, e_done;
   logic [15:0] e_h, e_x, e_z;
   logic [0:0]  e_idx;

   est_output_mxv #(.N(16), .FRAC(8), .ROWS(2), .COLS(2), .ROUND(0), .SAT(0)) u_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .h_flat(a_h), .x_flat(a_x),
      .busy(a_busy), .row_valid(a_rv), .row_idx(a_idx), .done(a_done), .Z(a_z));
   est_output_mxv #(.N(16), .FRAC(8), .ROWS(3), .COLS(3), .ROUND(0), .SAT(0)) u_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .h_flat(b_h), .x_flat(b_x),
      .busy(b_busy), .row_valid(b_rv), .row_idx(b_idx), .done(b_done), .Z(b_z));
   est_output_mxv #(.N(16), .FRAC(8), .ROWS(2), .COLS(2), .ROUND(0), .SAT(1)) u_c (
      .clk(clk), .rst_n(rst_n), .start(c_start), .h_flat(c_h), .x_flat(c_x),
      .busy(c_busy), .row_valid(c_rv), .row_idx(c_idx), .done(c_done), .Z(c_z));
   est_output_mxv #(.N(16), .FRAC(8), .ROWS(1), .COLS(1), .ROUND(0), .SAT(0)) u_d (
      .clk(clk), .rst_n(rst_n), .start(d_start), .h_flat(d_h), .x_flat(d_x),
      .busy(d_busy), .row_valid(d_rv), .row_idx(d_idx), .done(d_done), .Z(d_z));
   est_output_mxv #(.N(16), .FRAC(8), .ROWS(1), .COLS(1), .ROUND(1), .SAT(0)) u_e (
      .clk(clk), .rst_n(rst_n), .start(e_start), .h_flat(e_h), .x_flat(e_x),
      .busy(e_busy), .row_valid(e_rv), .row_idx(e_idx), .done(e_done), .Z(e_z));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1;
      a_start = 0; a_h = '0; a_x = '0;
      b_start = 0; b_h = '0; b_x = '0;
      c_start = 0; c_h = '0; c_x = '0;
      d_start = 0; d_h = '0; d_x = '0;
      e_start = 0; e_h = '0; e_x = '0;
      #2 rst_n = 1'b0;
      step();
      step();
      check("rst_a_busy", a_busy, 0);
      check("rst_a_rv",   a_rv,   0);
      check("rst_a_idx",  a_idx,  0);
      check("rst_a_done", a_done, 0);
      check("rst_a_z",    a_z,    0);
      check("rst_b_z",    b_z,    0);
      rst_n = 1'b1;
      step();

      // 2x2 basic; start held through E1 with new buses must be ignored
      a_h = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
      a_x = {16'h0040, 16'h0080};
      a_start = 1;
      step();
      check("t1_e0_busy", a_busy, 1);
      check("t1_e0_rv",   a_rv,   0);
      a_h = {16'h1234, 16'h7777, 16'h8001, 16'h0F0F};
      a_x = {16'h0555, 16'hF00F};
      step();
      a_start = 0;
      check("t1_e1_rv",   a_rv,   1);
      check("t1_e1_idx",  a_idx,  0);
      check("t1_e1_row0", a_z[15:0], 16'h0100);
      check("t1_e1_done", a_done, 0);
      check("t1_e1_busy", a_busy, 1);
      step();
      check("t1_e2_rv",   a_rv,   1);
      check("t1_e2_idx",  a_idx,  1);
      check("t1_e2_z",    a_z,    32'h0280_0100);
      check("t1_e2_done", a_done, 1);
      check("t1_e2_busy", a_busy, 0);
      step();
      check("t1_e3_done", a_done, 0);
      check("t1_e3_rv",   a_rv,   0);
      check("t1_e3_busy", a_busy, 0);

      // 3x3, odd COLS: row pulses at E2, E4, E6
      b_h = {9{16'h0100}};
      b_x = {16'h0300, 16'h0200, 16'h0100};
      b_start = 1;
      step();
      b_start = 0;
      check("t2_e0_busy", b_busy, 1);
      for (int n = 1; n <= 7; n++) begin
         step();
         check("t2_rv",   b_rv,   (n % 2 == 0) && (n <= 6));
         check("t2_done", b_done, n == 6);
         check("t2_busy", b_busy, n < 6);
         if (n % 2 == 0 && n <= 6) check("t2_idx", b_idx, n / 2 - 1);
      end
      check("t2_z", b_z, {3{16'h0600}});

      // saturation vs wrap, positive then negative overflow
      a_h = {16'h0000, 16'h0000, 16'h7F00, 16'h7F00};
      a_x = {16'h0100, 16'h0100};
      c_h = a_h;
      c_x = a_x;
      a_start = 1;
      c_start = 1;
      step();
      a_start = 0;
      c_start = 0;
      step();
      step();
      check("t3_done_c", c_done, 1);
      check("t3_wrap_pos", a_z, 32'h0000_FE00);
      check("t3_sat_pos",  c_z, 32'h0000_7FFF);
      a_h = {16'h0000, 16'h0000, 16'h8100, 16'h8100};
      c_h = a_h;
      a_start = 1;
      c_start = 1;
      step();
      a_start = 0;
      c_start = 0;
      step();
      step();
      check("t3_wrap_neg", a_z, 32'h0000_0200);
      check("t3_sat_neg",  c_z, 32'h0000_8000);

      // 1x1 rounding, L = 1
      d_h = 16'h0001; d_x = 16'h0080;
      e_h = 16'h0001; e_x = 16'h0080;
      d_start = 1;
      e_start = 1;
      step();
      d_start = 0;
      e_start = 0;
      check("t4_e0_busy", d_busy, 1);
      step();
      check("t4_done",     d_done, 1);
      check("t4_trunc_p",  d_z, 16'h0000);
      check("t4_round_p",  e_z, 16'h0001);
      d_h = 16'hFFFF;
      e_h = 16'hFFFF;
      d_start = 1;
      e_start = 1;
      step();
      d_start = 0;
      e_start = 0;
      step();
      check("t4_trunc_n",  d_z, 16'hFFFF);
      check("t4_round_n",  e_z, 16'h0000);

      // reset at E1 of a 3x3 run
      b_start = 1;
      step();
      b_start = 0;
      step();
      rst_n = 1'b0;
      #1;
      check("t5_rst_busy", b_busy, 0);
      check("t5_rst_rv",   b_rv,   0);
      check("t5_rst_done", b_done, 0);
      check("t5_rst_idx",  b_idx,  0);
      check("t5_rst_z",    b_z,    0);
      step();
      rst_n = 1'b1;
      for (int n = 0; n < 8; n++) begin
         step();
         check("t5_no_done", b_done, 0);
         check("t5_no_rv",   b_rv,   0);
      end
      b_x = {16'h0100, 16'h0100, 16'h0100};
      b_start = 1;
      step();
      b_start = 0;
      repeat (6) step();
      check("t5_re_done", b_done, 1);
      check("t5_re_z",    b_z, {3{16'h0300}});

      // back-to-back with start held: period L+1 = 3
      a_h = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
      a_x = {16'h0040, 16'h0080};
      a_start = 1;
      for (int k = 0; k < 12; k++) begin
         step();
         check("t6_done", a_done, (k % 3) == 2);
         check("t6_rv",   a_rv,   (k % 3) != 0);
         check("t6_busy", a_busy, (k % 3) != 2);
         if ((k % 3) != 0) check("t6_idx", a_idx, ((k % 3) == 1) ? 0 : 1);
         if ((k % 3) == 2) check("t6_z", a_z, 32'h0280_0100);
      end
      a_start = 0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
